// File: rtl/reg_write_port.sv
// Byte-serial register write port: an external master shifts an N-byte word in
// over an 8-bit bus using asynchronous frame (enable) and byte (phase) strobes.
module reg_write_port #(
  parameter int NUM_REGS  = 4,
  parameter int REG_BYTES = 2,
  parameter int ADDR_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       phase,
  input  logic [ADDR_W-1:0]          address,
  input  logic [7:0]                 data,
  input  logic                       clear_err,
  output logic [NUM_REGS*8*REG_BYTES-1:0] registers_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       busy,
  output logic [3:0]                 err
);

  localparam int W     = 8 * REG_BYTES;
  localparam int CNT_W = $clog2(REG_BYTES + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(REG_BYTES);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic en_meta, en_sync, en_prev;
  logic ph_meta, ph_sync, ph_prev;
  logic en_rise, en_fall, ph_tog;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [W-1:0]     temp, temp_next;
  logic             capture, commit, addr_ok;
  logic [3:0]       err_set;

  // Two-flop synchronisers plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta <= 1'b0;
      en_sync <= 1'b0;
      en_prev <= 1'b0;
      ph_meta <= 1'b0;
      ph_sync <= 1'b0;
      ph_prev <= 1'b0;
    end else begin
      en_meta <= enable;
      en_sync <= en_meta;
      en_prev <= en_sync;
      ph_meta <= phase;
      ph_sync <= ph_meta;
      ph_prev <= ph_sync;
    end
  end

  assign en_rise = en_sync & ~en_prev;
  assign en_fall = ~en_sync & en_prev;
  assign ph_tog  = ph_sync ^ ph_prev;
  assign addr_ok = ({1'b0, address} < NUM_REGS_L);
  assign busy    = (state != S_IDLE);

  // First byte ends up in the MSB once the frame is complete.
  generate
    if (REG_BYTES == 1) begin : g_single
      assign temp_next = data;
    end else begin : g_multi
      assign temp_next = {temp[W-9:0], data};
    end
  endgenerate

  // Enable fall is tested before phase toggle so it wins when both arrive together.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    commit  = 1'b0;
    err_set = 4'b0000;
    case (state)
      S_IDLE: begin
        if (en_rise) begin
          if (ph_sync) begin
            capture = 1'b1;
            cnt_n   = CNT_W'(1);
            state_n = (REG_BYTES == 1) ? S_DONE : S_LOAD;
          end else begin
            err_set[0] = 1'b1;
            state_n    = S_ERROR;
          end
        end
      end
      S_LOAD: begin
        if (en_fall) begin
          err_set[1] = 1'b1;
          state_n    = S_IDLE;
        end else if (ph_tog) begin
          capture = 1'b1;
          cnt_n   = cnt + 1'b1;
          if (cnt_n == LAST_CNT) state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (en_fall) begin
          if (addr_ok) commit = 1'b1;
          else         err_set[3] = 1'b1;
          state_n = S_IDLE;
        end else if (ph_tog) begin
          err_set[2] = 1'b1;
          state_n    = S_ERROR;
        end
      end
      S_ERROR: begin
        if (en_fall) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A new error in the same cycle as clear_err survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      temp           <= '0;
      registers_flat <= '0;
      wr_pulse       <= 1'b0;
      wr_addr        <= '0;
      err            <= 4'b0000;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wr_pulse <= commit;
      err      <= (clear_err ? 4'b0000 : err) | err_set;
      if (capture) temp <= temp_next;
      if (commit) wr_addr <= address;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && (address == ADDR_W'(i))) registers_flat[i*W +: W] <= temp;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_port.sv
// Directed self-checking bench for reg_write_port: default, 3-byte/8-reg and
// 1-byte instances driven with hand-computed expected values.
module tb_reg_write_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en_bus = 3'b000;
  logic        phase = 1'b0;
  logic [3:0]  address = 4'd0;
  logic [7:0]  data = 8'd0;
  logic        clear_err = 1'b0;

  logic [63:0]  regs_a;
  logic         wr_pulse_a, busy_a;
  logic [3:0]   wr_addr_a, err_a;
  logic [191:0] regs_b;
  logic         wr_pulse_b, busy_b;
  logic [3:0]   wr_addr_b, err_b;
  logic [31:0]  regs_c;
  logic         wr_pulse_c, busy_c;
  logic [3:0]   wr_addr_c, err_c;

  int n_compared = 0;
  int n_mismatched = 0;
  int pulse_cnt_a = 0;
  int pulse_base;

  always #5 clk = ~clk;

  reg_write_port #(.NUM_REGS(4), .REG_BYTES(2), .ADDR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_bus[0]), .phase(phase),
    .address(address), .data(data), .clear_err(clear_err),
    .registers_flat(regs_a), .wr_pulse(wr_pulse_a), .wr_addr(wr_addr_a),
    .busy(busy_a), .err(err_a)
  );

  reg_write_port #(.NUM_REGS(8), .REG_BYTES(3), .ADDR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_bus[1]), .phase(phase),
    .address(address), .data(data), .clear_err(clear_err),
    .registers_flat(regs_b), .wr_pulse(wr_pulse_b), .wr_addr(wr_addr_b),
    .busy(busy_b), .err(err_b)
  );

  reg_write_port #(.NUM_REGS(4), .REG_BYTES(1), .ADDR_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en_bus[2]), .phase(phase),
    .address(address), .data(data), .clear_err(clear_err),
    .registers_flat(regs_c), .wr_pulse(wr_pulse_c), .wr_addr(wr_addr_c),
    .busy(busy_c), .err(err_c)
  );

  // Each cycle of wr_pulse is counted, so a stretched pulse shows up as 2+.
  always @(negedge clk) begin
    if (wr_pulse_a) pulse_cnt_a++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive pins on a falling edge, then give the synchronisers 4 edges to act.
  task automatic applyStimulus(input logic [2:0] en_v, input logic ph_v,
                               input logic [7:0] d_v, input logic [3:0] addr_v);
    @(negedge clk);
    en_bus  = en_v;
    phase   = ph_v;
    data    = d_v;
    address = addr_v;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    #1;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_regs", regs_a, 64'h0);
    checkOutput("reset_pulse", wr_pulse_a, 1'b0);
    checkOutput("reset_wr_addr", wr_addr_a, 4'd0);
    checkOutput("reset_busy", busy_a, 1'b0);
    checkOutput("reset_err", err_a, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1. Nominal write of 0xBEEF to register 2
    pulse_base = pulse_cnt_a;
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd0);
    applyStimulus(3'b001, 1'b1, 8'hBE, 4'd0);
    checkOutput("nom_busy_mid", busy_a, 1'b1);
    applyStimulus(3'b001, 1'b0, 8'hEF, 4'd0);
    applyStimulus(3'b000, 1'b0, 8'hEF, 4'd2);
    checkOutput("nom_regs", regs_a, 64'h0000_BEEF_0000_0000);
    checkOutput("nom_wr_addr", wr_addr_a, 4'd2);
    checkOutput("nom_err", err_a, 4'b0000);
    checkOutput("nom_busy_end", busy_a, 1'b0);
    checkOutput("nom_pulse_cnt", pulse_cnt_a - pulse_base, 1);

    // 2. Bad start: phase low at frame start
    pulse_base = pulse_cnt_a;
    applyStimulus(3'b001, 1'b0, 8'h11, 4'd1);
    checkOutput("bs_err", err_a, 4'b0001);
    checkOutput("bs_busy", busy_a, 1'b1);
    applyStimulus(3'b001, 1'b1, 8'h22, 4'd1);
    applyStimulus(3'b001, 1'b0, 8'h33, 4'd1);
    checkOutput("bs_busy_toggles", busy_a, 1'b1);
    applyStimulus(3'b000, 1'b0, 8'h33, 4'd1);
    checkOutput("bs_busy_end", busy_a, 1'b0);
    checkOutput("bs_regs", regs_a, 64'h0000_BEEF_0000_0000);
    checkOutput("bs_pulse_cnt", pulse_cnt_a - pulse_base, 0);
    checkOutput("bs_err_sticky", err_a, 4'b0001);
    pulseClear();
    checkOutput("bs_clear", err_a, 4'b0000);

    // 3a. Short frame
    pulse_base = pulse_cnt_a;
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd1);
    applyStimulus(3'b001, 1'b1, 8'h12, 4'd1);
    applyStimulus(3'b000, 1'b1, 8'h12, 4'd1);
    checkOutput("short_err", err_a, 4'b0010);
    checkOutput("short_regs", regs_a, 64'h0000_BEEF_0000_0000);
    checkOutput("short_busy", busy_a, 1'b0);
    pulseClear();

    // 3b. Overrun: extra phase edge after the word is complete
    applyStimulus(3'b001, 1'b1, 8'hAA, 4'd1);
    applyStimulus(3'b001, 1'b0, 8'h55, 4'd1);
    applyStimulus(3'b001, 1'b1, 8'h66, 4'd1);
    checkOutput("ovr_err", err_a, 4'b0100);
    applyStimulus(3'b001, 1'b0, 8'h77, 4'd1);
    applyStimulus(3'b000, 1'b0, 8'h77, 4'd1);
    checkOutput("ovr_regs", regs_a, 64'h0000_BEEF_0000_0000);
    checkOutput("ovr_pulse_cnt", pulse_cnt_a - pulse_base, 0);
    checkOutput("ovr_err_end", err_a, 4'b0100);
    pulseClear();

    // 4. Bad address, clear, then clear coincident with a new bad start
    pulse_base = pulse_cnt_a;
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd5);
    applyStimulus(3'b001, 1'b1, 8'h12, 4'd5);
    applyStimulus(3'b001, 1'b0, 8'h34, 4'd5);
    applyStimulus(3'b000, 1'b0, 8'h34, 4'd5);
    checkOutput("badaddr_err", err_a, 4'b1000);
    checkOutput("badaddr_regs", regs_a, 64'h0000_BEEF_0000_0000);
    checkOutput("badaddr_pulse_cnt", pulse_cnt_a - pulse_base, 0);
    checkOutput("badaddr_wr_addr", wr_addr_a, 4'd2);
    pulseClear();
    checkOutput("badaddr_clear", err_a, 4'b0000);
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd9);
    applyStimulus(3'b001, 1'b1, 8'h12, 4'd9);
    applyStimulus(3'b001, 1'b0, 8'h34, 4'd9);
    applyStimulus(3'b000, 1'b0, 8'h34, 4'd9);
    checkOutput("badaddr2_err", err_a, 4'b1000);
    // enable pin rises before edge k; the error lands on edge k+2
    @(negedge clk);
    en_bus = 3'b001;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    clear_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_err = 1'b0;
    #1;
    checkOutput("clear_vs_set_err", err_a, 4'b0001);
    applyStimulus(3'b000, 1'b0, 8'h00, 4'd0);
    pulseClear();

    // 5a. Enable fall and phase toggle in the same cycle while loading
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd0);
    applyStimulus(3'b001, 1'b1, 8'h11, 4'd0);
    applyStimulus(3'b000, 1'b0, 8'h22, 4'd0);
    checkOutput("prio_err", err_a, 4'b0010);
    checkOutput("prio_busy", busy_a, 1'b0);
    checkOutput("prio_regs", regs_a, 64'h0000_BEEF_0000_0000);
    pulseClear();

    // 5b. Reset mid-frame, then a clean frame afterwards
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd0);
    applyStimulus(3'b001, 1'b1, 8'h77, 4'd0);
    checkOutput("rst_busy_before", busy_a, 1'b1);
    @(negedge clk);
    rst_n  = 1'b0;
    en_bus = 3'b000;
    phase  = 1'b0;
    #1;
    checkOutput("rst_regs", regs_a, 64'h0);
    checkOutput("rst_busy", busy_a, 1'b0);
    checkOutput("rst_wr_addr", wr_addr_a, 4'd0);
    checkOutput("rst_err", err_a, 4'b0000);
    checkOutput("rst_pulse", wr_pulse_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    pulse_base = pulse_cnt_a;
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd0);
    applyStimulus(3'b001, 1'b1, 8'hCA, 4'd0);
    applyStimulus(3'b001, 1'b0, 8'hFE, 4'd0);
    applyStimulus(3'b000, 1'b0, 8'hFE, 4'd0);
    checkOutput("post_rst_regs", regs_a, 64'h0000_0000_0000_CAFE);
    checkOutput("post_rst_wr_addr", wr_addr_a, 4'd0);
    checkOutput("post_rst_pulse_cnt", pulse_cnt_a - pulse_base, 1);
    checkOutput("post_rst_err", err_a, 4'b0000);

    // 6a. Three-byte word into the last of eight registers
    applyStimulus(3'b000, 1'b1, 8'h00, 4'd0);
    applyStimulus(3'b010, 1'b1, 8'h12, 4'd0);
    applyStimulus(3'b010, 1'b0, 8'h34, 4'd0);
    applyStimulus(3'b010, 1'b1, 8'h56, 4'd0);
    applyStimulus(3'b000, 1'b1, 8'h56, 4'd7);
    checkOutput("b_regs", regs_b, {24'h123456, 168'h0});
    checkOutput("b_wr_addr", wr_addr_b, 4'd7);
    checkOutput("b_err", err_b, 4'b0000);
    checkOutput("a_untouched", regs_a, 64'h0000_0000_0000_CAFE);

    // 6b. Single-byte word goes straight to DONE
    applyStimulus(3'b100, 1'b1, 8'h9C, 4'd0);
    checkOutput("c_busy", busy_c, 1'b1);
    applyStimulus(3'b000, 1'b1, 8'h9C, 4'd0);
    checkOutput("c_regs", regs_c, 32'h0000_009C);
    checkOutput("c_err", err_c, 4'b0000);
    checkOutput("c_busy_end", busy_c, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reg_write_port.md
# reg_write_port

Parametrised byte-serial register write port: an external master shifts an N-byte word in over an 8-bit bus using two asynchronous strobes, `enable` (frame) and `phase` (byte clock). The word is committed to one of NUM_REGS registers on frame end. It is the next-generation configuration front-end, adding:
- configurable register width and count,
- a write-commit strobe,
- sticky error reporting.

## Interface
Parameters:
- NUM_REGS, 4, number of registers (1..2^ADDR_W)
- REG_BYTES, 2, bytes per register (≥1); register width W = 8*REG_BYTES
- ADDR_W, 4, address bus width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  frame strobe, asynchronous to clk
- phase  in  1  byte strobe, asynchronous to clk
- address  in  ADDR_W  target register, sampled unsynchronised at commit
- data  in  8  byte value, sampled unsynchronised at byte capture
- clear_err  in  1  synchronous pulse, clears err
- registers_flat  out  NUM_REGS*W  register i at bits [i*W +: W]
- wr_pulse  out  1  one-cycle commit strobe
- wr_addr  out  ADDR_W  address of last commit
- busy  out  1  high whenever state ≠ IDLE
- err  out  4  sticky error flags: [0] bad start, [1] short frame, [2] overrun, [3] bad address

## Operation
Strobe conditioning:
- `enable` and `phase` each pass through a two-flop synchroniser (reset to 0), then a one-flop delay.
- Rise = s & ~p; fall = ~s & p; phase toggle = s ^ p.

Capture:
- Byte capture shifts a W-bit temp register: temp <= {temp[W-9:0], data}.
- The first byte lands in the MSB.
- byte_cnt counts bytes captured in the current frame.

States:
- IDLE
  - enable rise with phase_s=1: capture byte, cnt=1; go to LOAD, or to DONE if REG_BYTES=1.
  - enable rise with phase_s=0: set err[0]; go to ERROR.
- LOAD
  - enable fall: set err[1]; go to IDLE; no write.
  - otherwise phase toggle (either edge): capture byte, cnt+1; go to DONE when cnt reaches REG_BYTES.
- DONE
  - enable fall with address < NUM_REGS: registers[address] <= temp; wr_pulse=1; wr_addr <= address; go to IDLE.
  - enable fall with address ≥ NUM_REGS: set err[3]; no write, no pulse; go to IDLE.
  - otherwise phase toggle: set err[2]; go to ERROR.
- ERROR
  - enable fall: go to IDLE; all phase activity is ignored until then.

Error flags and boundaries:
- err bits are OR-accumulated.
- clear_err zeroes err; an error set in the same cycle as clear_err wins (that bit stays set).
- Enable fall and phase toggle detected in the same cycle: enable fall has priority and the toggle is ignored.
- Registers change only on a successful commit; a failed frame leaves all registers untouched.
- Reset mid-frame: state, cnt, temp, registers, err, wr_pulse, wr_addr and synchronisers all return to reset values.
- If `enable` is held high through reset release, the synchronised rise is detected and treated as a frame start.

## Timing
- Reset values: registers_flat=0, wr_pulse=0, wr_addr=0, busy=0, err=0.
- Strobe latency: a pin edge settling before clk edge k is acted on at edge k+2, because synchroniser output is valid after edge k+1.
- Master data/address setup: data (and address at frame end) must be stable from the strobe pin edge through 3 clk edges afterwards.
- Minimum strobe pulse: enable and phase levels must each be held ≥3 clk cycles between edges.
- Commit edge:
  - registers_flat, wr_addr and err update at the commit edge itself.
  - wr_pulse is high for exactly the one cycle following that edge.
  - busy drops at the same edge.
- Max throughput: one byte per 3 clk cycles.

## Test plan
Defaults unless stated: NUM_REGS=4, REG_BYTES=2.
1. Nominal write: enable↑ with phase=1, data=0xBE; phase↓, data=0xEF; enable↓, address=2 -> registers_flat[47:32]=0xBEEF, other registers 0, wr_pulse high one cycle, wr_addr=2, err=0, busy back to 0.
2. Bad start: enable↑ with phase=0, then phase toggles, then enable↓ -> err=4'b0001, no register change, no wr_pulse, busy high until enable fall is detected.
3. Short frame and overrun:
   - enable↓ after only the first byte (0x12) -> err[1]=1, registers unchanged.
   - Next frame, 0xAA then 0x55 then an extra phase↑ -> err[2]=1, no write on enable↓.
4. Bad address and clear:
   - Full frame 0x1234 with address=5 -> err[3]=1, no wr_pulse, registers unchanged.
   - clear_err pulse -> err=0.
   - clear_err coincident with a new bad-start error -> err[0]=1.
5. Priority and reset:
   - enable↓ and phase toggle detected in the same cycle while in LOAD -> only err[1] set.
   - Assert rst_n low mid-frame after one byte -> all outputs 0; a subsequent full frame 0xCAFE to address 0 commits correctly.
6. Generalisation, REG_BYTES=3, NUM_REGS=8:
   - Bytes 0x12/0x34/0x56 via enable↑, phase↓, phase↑, address=7 -> registers_flat[191:168]=0x123456.
   - REG_BYTES=1 instance: enable↑ with 0x9C then enable↓, address=0 -> register 0 = 0x9C.
